eth_mac_init: RTL
=================

ETH_MAC_INIT -- requirements
Module: eth_mac_init

Interface
REQ-001 SHALL have parameter MAC_ADDR, default 48'h02_00_00_00_00_01, station address written to the MAC (byte 0 = bits 47:40).
REQ-002 SHALL have parameter MAX_FRAME, default 16'd1518, value written to the frm_length register.
REQ-003 SHALL have parameter POLL_LIMIT, default 1024, maximum number of SW_RESET poll reads before error.
REQ-004 SHALL have parameter PROMISC, default 1'b0, driven onto the PROMIS_EN bit.
REQ-005 SHALL have ports: clk  in  1  single clock; all logic is on this clock.
REQ-006 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: start  in  1  one-cycle pulse that begins or restarts the sequence.
REQ-008 SHALL have ports: gig_mode  in  1  ETH_SPEED value, sampled when start is accepted.
REQ-009 SHALL have ports: reg_addr  out  8  MAC control-port word address.
REQ-010 SHALL have ports: reg_wr / reg_rd  out  1 each  write and read strobes.
REQ-011 SHALL have ports: reg_data_in  out  32  write data (MAC writedata).
REQ-012 SHALL have ports: reg_data_out  in  32  read data (MAC readdata).
REQ-013 SHALL have ports: reg_busy  in  1  waitrequest.
REQ-014 SHALL have ports: busy, done, error  out  1 each  sequence status.

Function
REQ-015 SHALL implement states IDLE, WR_DIS, WR_MAC0, WR_MAC1, WR_FRM, WR_RST, POLL, WR_EN, DONE, ERR.
REQ-016 SHALL leave IDLE, DONE or ERR for WR_DIS on start; start in any other state SHALL be ignored.
REQ-017 SHALL perform these writes in order:
- WR_DIS: addr 0x02, data = cfg with TX_ENA = RX_ENA = 0.
- WR_MAC0: addr 0x03, data = MAC_ADDR[23:0]/[47:24] byte-swapped, i.e. {b3,b2,b1,b0}.
- WR_MAC1: addr 0x04, data = {16'h0, b5, b4}.
- WR_FRM: addr 0x05, data = {16'h0, MAX_FRAME}.
- WR_RST: addr 0x02, data = cfg | bit13.
- WR_EN: addr 0x02, data = cfg | bit0 | bit1.
REQ-018 SHALL define cfg as bit3 = latched gig_mode, bit4 = PROMISC, all other bits 0.
REQ-019 SHALL hold reg_addr, reg_data_in and the strobe stable while reg_busy = 1; a transfer completes in the first cycle with strobe = 1 and reg_busy = 0.
REQ-020 SHALL advance state on the cycle after completion; strobes SHALL deassert for exactly one cycle between consecutive transfers.
REQ-021 SHALL never assert reg_rd and reg_wr together.
REQ-022 In POLL, SHALL issue reads of addr 0x02 and sample reg_data_out at completion: bit13 = 0 -> WR_EN; bit13 = 1 -> increment the 16-bit poll counter and read again.
REQ-023 SHALL go to ERR when the poll counter reaches POLL_LIMIT with bit13 still 1; the counter clears on entry to POLL.
REQ-024 SHALL drive busy = 1 in all states except IDLE, DONE and ERR.
REQ-025 SHALL drive done = 1 only in DONE and error = 1 only in ERR; both SHALL be registered outputs.
REQ-026 SHALL ignore reg_busy and reg_data_out whenever no strobe is asserted.

Reset
REQ-027 reset_n = 0 SHALL asynchronously force state IDLE, reg_wr = reg_rd = 0, reg_addr = 0, reg_data_in = 0, busy = done = error = 0, poll counter = 0, latched gig_mode = 0.
REQ-028 Reset mid-transfer SHALL drop strobes immediately; the sequence SHALL NOT resume until the next start.

Structure
REQ-029 Register word addresses (0x02, 0x03, 0x04, 0x05), the command_config bit indices (0, 1, 3, 4, 13) and the state encoding SHALL live in the shared package eth_pkg.
REQ-030 A single sub-module eth_reg_master SHALL own the strobe/waitrequest handshake and return a one-cycle xfer_done with captured read data.

Verification
REQ-031 MAC model with reg_busy = 0, gig_mode = 1, start -> six writes in order with data 0x0000_0008, 0x0000_0000-swap of MAC_ADDR, ..., 0x0000_05EE, 0x0000_2008, 0x0000_000B; done = 1.
REQ-032 reg_busy held for 3 cycles per access -> strobe, address and data are stable across the hold; completion occurs one cycle after reg_busy falls; the sequence is identical.
REQ-033 bit13 reads back 1 for 5 reads, then 0 -> exactly 6 reads of 0x02, then the WR_EN write.
REQ-034 bit13 stuck at 1 with POLL_LIMIT = 8 -> ERR after 8 reads, error = 1, no WR_EN write; a subsequent start reruns from WR_DIS.
REQ-035 reset_n pulled low during WR_FRM with reg_busy = 1 -> strobes are 0 in the same cycle and all outputs equal their reset values.
REQ-036 start pulsed during POLL -> ignored; the sequence completes normally.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet MAC bring-up sequencer: control-port word
// addresses, command_config bit positions and the sequencer state encoding.
package eth_pkg;

  localparam logic [7:0] AddrCmdCfg = 8'h02;
  localparam logic [7:0] AddrMac0   = 8'h03;
  localparam logic [7:0] AddrMac1   = 8'h04;
  localparam logic [7:0] AddrFrmLen = 8'h05;

  localparam int unsigned TxEnaBit    = 0;
  localparam int unsigned RxEnaBit    = 1;
  localparam int unsigned EthSpeedBit = 3;
  localparam int unsigned PromisEnBit = 4;
  localparam int unsigned SwResetBit  = 13;

  typedef enum logic [3:0] {
    StIdle,
    StWrDis,
    StWrMac0,
    StWrMac1,
    StWrFrm,
    StWrRst,
    StPoll,
    StWrEn,
    StDone,
    StErr
  } state_e;

  // Base command_config value: only speed and promiscuous bits, MAC disabled.
  function automatic logic [31:0] cfg_word(input logic gig, input logic promisc);
    logic [31:0] w;
    w              = '0;
    w[EthSpeedBit] = gig;
    w[PromisEnBit] = promisc;
    return w;
  endfunction

endpackage

// File: rtl/eth_reg_master.sv
// Single-outstanding control-port master: holds strobe/address/data until
// waitrequest drops, then pulses xfer_done_o with the captured read data.
module eth_reg_master (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  input  logic        cmd_wr_i,
  input  logic [7:0]  cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic        reg_busy_i,
  input  logic [31:0] reg_rdata_i,
  output logic [7:0]  reg_addr_o,
  output logic        reg_wr_o,
  output logic        reg_rd_o,
  output logic [31:0] reg_wdata_o,
  output logic        xfer_done_o,
  output logic [31:0] rdata_o
);

  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    if (wr_q || rd_q) begin
      // waitrequest is only meaningful while a strobe is up
      if (!reg_busy_i) begin
        wr_d   = 1'b0;
        rd_d   = 1'b0;
        done_d = 1'b1;
        if (rd_q) begin
          rdata_d = reg_rdata_i;
        end
      end
    end else if (cmd_valid_i) begin
      wr_d    = cmd_wr_i;
      rd_d    = !cmd_wr_i;
      addr_d  = cmd_addr_i;
      wdata_d = cmd_wr_i ? cmd_wdata_i : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign reg_addr_o  = addr_q;
  assign reg_wr_o    = wr_q;
  assign reg_rd_o    = rd_q;
  assign reg_wdata_o = wdata_q;
  assign xfer_done_o = done_q;
  assign rdata_o     = rdata_q;

endmodule

// File: rtl/eth_mac_init.sv
// Ethernet MAC bring-up sequencer: disables the MAC, programs station address and
// frame length, issues a software reset, polls for its completion, then enables TX/RX.
module eth_mac_init
  import eth_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR   = 48'h02_00_00_00_00_01,
  parameter logic [15:0] MAX_FRAME  = 16'd1518,
  parameter int unsigned POLL_LIMIT = 1024,
  parameter logic        PROMISC    = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        gig_mode,
  output logic [7:0]  reg_addr,
  output logic        reg_wr,
  output logic        reg_rd,
  output logic [31:0] reg_data_in,
  input  logic [31:0] reg_data_out,
  input  logic        reg_busy,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] PollLimit = 17'(POLL_LIMIT);

  state_e      state_q, state_d;
  logic        gig_q, gig_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        launch;
  logic        cmd_wr;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        xfer_done;
  logic [31:0] rdata;
  logic [16:0] poll_inc;
  logic [31:0] cfg;
  logic        unused_rdata;

  assign poll_inc     = {1'b0, poll_cnt_q} + 17'd1;
  assign unused_rdata = ^rdata;

  eth_reg_master u_reg_master (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .cmd_valid_i (launch),
    .cmd_wr_i    (cmd_wr),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .reg_busy_i  (reg_busy),
    .reg_rdata_i (reg_data_out),
    .reg_addr_o  (reg_addr),
    .reg_wr_o    (reg_wr),
    .reg_rd_o    (reg_rd),
    .reg_wdata_o (reg_data_in),
    .xfer_done_o (xfer_done),
    .rdata_o     (rdata)
  );

  // Next-state: each transfer is launched in the same cycle the state is entered.
  always_comb begin
    state_d    = state_q;
    gig_d      = gig_q;
    poll_cnt_d = poll_cnt_q;
    launch     = 1'b0;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StWrDis;
          gig_d   = gig_mode;
          launch  = 1'b1;
        end
      end
      StWrDis: begin
        if (xfer_done) begin
          state_d = StWrMac0;
          launch  = 1'b1;
        end
      end
      StWrMac0: begin
        if (xfer_done) begin
          state_d = StWrMac1;
          launch  = 1'b1;
        end
      end
      StWrMac1: begin
        if (xfer_done) begin
          state_d = StWrFrm;
          launch  = 1'b1;
        end
      end
      StWrFrm: begin
        if (xfer_done) begin
          state_d = StWrRst;
          launch  = 1'b1;
        end
      end
      StWrRst: begin
        if (xfer_done) begin
          state_d    = StPoll;
          poll_cnt_d = '0;
          launch     = 1'b1;
        end
      end
      StPoll: begin
        if (xfer_done) begin
          if (!rdata[SwResetBit]) begin
            state_d = StWrEn;
            launch  = 1'b1;
          end else begin
            poll_cnt_d = poll_inc[15:0];
            if (poll_inc >= PollLimit) begin
              state_d = StErr;
            end else begin
              launch = 1'b1;
            end
          end
        end
      end
      StWrEn: begin
        if (xfer_done) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Command for the state being entered; uses the freshly latched speed bit.
  assign cfg = cfg_word(gig_d, PROMISC);

  always_comb begin
    cmd_wr    = 1'b1;
    cmd_addr  = AddrCmdCfg;
    cmd_wdata = '0;
    case (state_d)
      StWrDis: cmd_wdata = cfg;
      StWrMac0: begin
        cmd_addr  = AddrMac0;
        cmd_wdata = {MAC_ADDR[23:16], MAC_ADDR[31:24], MAC_ADDR[39:32], MAC_ADDR[47:40]};
      end
      StWrMac1: begin
        cmd_addr  = AddrMac1;
        cmd_wdata = {16'h0000, MAC_ADDR[7:0], MAC_ADDR[15:8]};
      end
      StWrFrm: begin
        cmd_addr  = AddrFrmLen;
        cmd_wdata = {16'h0000, MAX_FRAME};
      end
      StWrRst: cmd_wdata = cfg | (32'd1 << SwResetBit);
      StPoll:  cmd_wr = 1'b0;
      StWrEn:  cmd_wdata = cfg | (32'd1 << TxEnaBit) | (32'd1 << RxEnaBit);
      default: ;
    endcase
  end

  always_comb begin
    busy_d  = !(state_d inside {StIdle, StDone, StErr});
    done_d  = (state_d == StDone);
    error_d = (state_d == StErr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      gig_q      <= 1'b0;
      poll_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gig_q      <= gig_d;
      poll_cnt_q <= poll_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule
